// File: rtl/nonce_result_writer.sv
// Write-back stage: captures every lane's final H0 word plus a base address on start,
// then streams the words to memory in nonce order. Optional checksum write: NONCE_RESULT_CHECKSUM_EN.
module nonce_result_writer #(
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [NUM_NONCES*WORD_W-1:0] h0_in,
  input  logic                         mem_ready,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD_W-1:0]            mem_write_data,
  output logic                         busy,
  output logic                         done
);

`ifdef NONCE_RESULT_CHECKSUM_EN
  localparam int NUM_WR = NUM_NONCES + 1;
`else
  localparam int NUM_WR = NUM_NONCES;
`endif
  localparam int IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WR - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                             state, state_d;
  logic [NUM_NONCES-1:0][WORD_W-1:0]  words_q;
  logic [ADDR_W-1:0]                  base_q;
  logic [IDX_W-1:0]                   idx, nxt;
  logic [WORD_W-1:0]                  nxt_word;
  logic                               xfer, last;

  assign xfer = mem_we & mem_ready;
  assign last = (idx == LAST);
  assign nxt  = idx + 1'b1;

`ifdef NONCE_RESULT_CHECKSUM_EN
  logic [WORD_W-1:0] csum;
  always_comb begin
    csum = '0;
    for (int i = 0; i < NUM_NONCES; i++) csum ^= words_q[i];
  end
`endif

  // Word presented after the current one transfers; index NUM_NONCES is the checksum slot.
  always_comb begin
    nxt_word = '0;
    for (int i = 0; i < NUM_NONCES; i++)
      if (nxt == IDX_W'(i)) nxt_word = words_q[i];
`ifdef NONCE_RESULT_CHECKSUM_EN
    if (nxt == IDX_W'(NUM_NONCES)) nxt_word = csum;
`endif
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_d;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (xfer && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture buffer needs no reset: it is only read after a start has loaded it.
  always_ff @(posedge clk)
    if (state == IDLE && start) words_q <= h0_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q         <= '0;
      idx            <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base_q         <= base_addr;
          idx            <= '0;
          mem_we         <= 1'b1;
          busy           <= 1'b1;
          mem_addr       <= base_addr;
          mem_write_data <= h0_in[WORD_W-1:0];
        end
        WRITE: if (xfer) begin
          if (last) begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            idx            <= nxt;
            mem_addr       <= base_q + ADDR_W'(nxt);
            mem_write_data <= nxt_word;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nonce_result_writer.md
Name: nonce_result_writer

Overview:
- Write-back stage at the end of the parallel nonce pipeline.
- On a start pulse, captures the final H0 digest word of every nonce lane and the base address into an internal buffer.
- Then writes the words one per accepted cycle to the output memory port, in nonce order 0..NUM_NONCES-1.
- Signals completion with a one-cycle done pulse.

Parameters:
- NUM_NONCES, 16, number of parallel nonce lanes whose results are written.
- ADDR_W, 16, memory address width.
- WORD_W, 32, digest word width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- base_addr  input  ADDR_W  first write address; captured with start.
- h0_in  input  NUM_NONCES*WORD_W  final H0 per nonce; nonce i at bits [WORD_W*i+WORD_W-1 : WORD_W*i]; captured with start.
- mem_ready  input  1  memory accepts the presented write this cycle.
- mem_we  output  1  write request valid.
- mem_addr  output  ADDR_W  write address.
- mem_write_data  output  WORD_W  write data.
- busy  output  1  high from the cycle after start acceptance until done.
- done  output  1  one-cycle pulse after the last accepted write.

Behaviour:
- Reset (async assert, sync release): state=IDLE; mem_we=0, mem_addr=0, mem_write_data=0, busy=0, done=0; index=0; buffer contents don't-care.
- States: IDLE, WRITE, DONE.
- IDLE:
  - start=1 -> capture h0_in into buffer, base_addr into addr register, index=0; next state WRITE.
  - start=0 -> stay in IDLE.
- WRITE:
  - Drives mem_we=1, mem_addr=base+index (modulo 2^ADDR_W), mem_write_data=buffer[index]. All are registered outputs, valid the cycle after start.
  - A word transfers when mem_we && mem_ready.
  - mem_ready=0 -> hold addr/data/we stable, no index advance.
  - On a transfer with index<NUM_NONCES-1 -> index+1 and next address/data presented the following cycle. Back-to-back: one word per cycle when mem_ready is held high.
  - On a transfer with index=NUM_NONCES-1 -> mem_we=0 next cycle; state DONE.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle; return to IDLE. A start in this cycle is ignored.
- busy=1 throughout WRITE.
- start while busy or in DONE: ignored; buffer and addresses unchanged.
- Latency with mem_ready held 1: start at cycle 0 -> first write cycle 1 -> last write cycle NUM_NONCES -> done at cycle NUM_NONCES+1.
- Address wrap: base+index overflows modulo 2^ADDR_W; no error.
- h0_in changes after capture have no effect on the written data.
- Reset mid-operation: mem_we drops immediately on assertion, no further writes, done not pulsed; after release the block is in IDLE awaiting a new start.

Optional Feature:
- Macro: NONCE_RESULT_CHECKSUM_EN.
- Defined:
  - After the NUM_NONCES data words, one extra write is issued at base+NUM_NONCES (wrapping).
  - Its data is the XOR of all NUM_NONCES captured words.
  - It uses the same mem_ready handshake.
  - done follows the checksum transfer, so latency grows by one write.
- Undefined: exactly NUM_NONCES writes; no checksum logic present.

Test Plan:
- Basic: base_addr=0x0010, h0_in nonce i = 0xA5A50000+i, mem_ready=1 -> 16 writes on consecutive cycles, addr 0x0010..0x001F, data 0xA5A50000..0xA5A5000F; done pulses at cycle 17 after start; busy high cycles 1..16.
- Backpressure: same stimulus, mem_ready=0 for 3 cycles during index 5 -> addr 0x0015 / data 0xA5A50005 held 4 cycles, no skipped or duplicated word; done delayed by 3 cycles.
- Wrap: base_addr=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007, data in nonce order.
- Ignore start: pulse start with different base_addr=0x1234 at write index 3 and in the DONE cycle -> original sequence unaffected; no second burst.
- Reset mid-burst: assert reset_n=0 after 6 accepted writes -> mem_we=0 immediately, done never pulses; after release, a new start with base_addr=0x0100 gives a full 16-word burst from 0x0100.
- Checksum (NONCE_RESULT_CHECKSUM_EN): words 0x00000001<<i, i=0..15 -> 17th write at base+16 with data 0x0000FFFF, then done.
